simon_playback_sequencer: RTL

Sequences playback of the stored Simon pattern sequence onto the game LEDs. On a start pulse from the Simon control FSM it reads each stored pattern from the pattern memory in order and shows it for a fixed on-time followed by a blank gap. It then returns a one-cycle done pulse. It sits between the control FSM, the pattern memory read port and the LED output mux, and owns the memory read address for the whole playback.

---
 rtl/simon_playback_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/simon_playback_sequencer.sv
// simon_playback_sequencer
// Plays the stored Simon pattern sequence onto the game LEDs. When it accepts a
// start pulse it fetches each pattern from the pattern memory in order, shows it
// for ON_CYCLES cycles, blanks the LEDs for GAP_CYCLES cycles, and then returns a
// one-cycle done pulse. It owns the memory read address for the whole playback.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        begin playback (sampled only in IDLE)
//   abort        cancel playback, back to IDLE; wins over a simultaneous start
//   seq_len      number of patterns to play, latched on an accepted start
//   mem_rdata    memory read data, valid the cycle after mem_ren
//   mem_ren      memory read enable (FETCH only)
//   mem_raddr    memory read address
//   led_pattern  pattern currently shown, 0 when nothing is shown
//   led_valid    high while led_pattern is shown
//   busy         high in every state except IDLE
//   done         one-cycle pulse when playback completes
module simon_playback_sequencer #(
  parameter int unsigned PAT_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   seq_len,
  input  logic [PAT_WIDTH-1:0]  mem_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [PAT_WIDTH-1:0]  led_pattern,
  output logic                  led_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned MAX_LEN = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PAT_WIDTH-1:0]  pat_q, pat_d;

  logic                  mem_ren_d;
  logic [ADDR_WIDTH-1:0] mem_raddr_d;
  logic [PAT_WIDTH-1:0]  led_pattern_d;
  logic                  led_valid_d;
  logic                  busy_d;
  logic                  done_d;

  logic [LEN_W-1:0]      len_clamp_c;

  // Requested length clamped to the memory depth
  assign len_clamp_c = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d   = len_clamp_c;
          idx_d   = '0;
          state_d = (len_clamp_c == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        pat_d   = mem_rdata;
        cnt_d   = CNT_WIDTH'(ON_CYCLES - 1);
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_WIDTH'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end

    // Outputs are decoded from the next state so the registers track the state
    mem_ren_d     = (state_d == S_FETCH);
    mem_raddr_d   = mem_ren_d ? idx_d[ADDR_WIDTH-1:0] : '0;
    led_valid_d   = (state_d == S_SHOW);
    led_pattern_d = led_valid_d ? pat_d : '0;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= '0;
      mem_ren     <= 1'b0;
      mem_raddr   <= '0;
      led_pattern <= '0;
      led_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      mem_ren     <= mem_ren_d;
      mem_raddr   <= mem_raddr_d;
      led_pattern <= led_pattern_d;
      led_valid   <= led_valid_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
